// File: rtl/seg7_scan_drv.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_drv
// Purpose  : Multiplexed 7-segment scan driver. Active-low segments, decimal
//            point and one-hot digit select, with hex decode, leading-zero
//            blanking and ghost blanking at the start of each digit slot.
//            Optional per-digit blinking is built only when SEG7_BLINK_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_drv #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  vld,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'h7F;

  logic [CNT_W-1:0]    slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] num_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic                slot_wrap;
  logic [DIGITS-1:0]   lz;
  logic                blink_cur;
  logic                blank_cur;
  logic [3:0]          nib_cur;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_OFF;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  // Derived from the counters so it is high during the cycle whose closing
  // edge wraps the index back to digit 0; reset forces both counters to 0.
  assign frame_tick = slot_wrap && (idx == IDX_LAST);

  // Shadow registers capture the display data on every load strobe
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      num_sh <= '0;
      dp_sh  <= '0;
    end else if (vld) begin
      num_sh <= num;
      dp_sh  <= dp_in;
    end
  end

  // Slot counter and digit index; the load strobe never touches the scan
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // lz[i] is set when nibbles i..DIGITS-1 are all zero
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign lz[gi] = ~|num_sh[4*DIGITS-1:4*gi];
    end
  endgenerate

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0]  blk_cnt;
  logic              blk_phase;
  logic [DIGITS-1:0] bm_sh;

  // Blink mask shadow follows the same load strobe as the digit data
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      bm_sh <= '0;
    end else if (vld) begin
      bm_sh <= blink_mask;
    end
  end

  // Free-running blink half-period counter toggling the blink phase
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      blk_phase <= 1'b0;
    end else if (blk_cnt == BLK_LAST) begin
      blk_cnt   <= '0;
      blk_phase <= ~blk_phase;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  assign blink_cur = blk_phase && bm_sh[idx];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_cur    = 1'b0;
`endif

  assign nib_cur   = num_sh[4*idx +: 4];
  // Digit 0 is never leading-zero blanked, so a zero value still shows "0"
  assign blank_cur = (blank_lz && (idx != '0) && lz[idx]) || blink_cur;

  // Registered outputs computed from the current index and shadows
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_OFF;
      seg_dp <= 1'b1;
      sel    <= '1;
    end else begin
      seg    <= blank_cur ? SEG_OFF : hex_decode(nib_cur);
      seg_dp <= blank_cur ? 1'b1 : ~dp_sh[idx];
      // All digits off for the first cycle of each slot to hide ghosting
      sel    <= (slot_cnt == '0) ? '1 : ~(DIGITS'(1) << idx);
    end
  end

endmodule
`default_nettype wire
